proc_core_param: RTL
====================

# proc_core_param

Parametrised multi-cycle processor core, the next generation of the per-core datapath used in the multi-core array. Data width, address width, PC width and register count are all configurable. The core has req/ack handshakes on both instruction and data memory, so a shared arbiter can insert wait states. Each core seeds two registers with its core ID and the total core count so that identical programs can partition work.

## Interface
- DATA_W, 32, datapath and register width
- ADDR_W, 12, data-memory address width
- PC_W, 6, program-counter / instruction-address width
- RIDX_W, 4, register index width; NREG = 2^RIDX_W registers
- ID_W, 3, width of core_id / n_cores
- INSTR_W (localparam) = 4 + 2*RIDX_W + ADDR_W; fields [op 4 | ra | rb | imm ADDR_W], op in MSBs

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- enable  in  1  start/continue permission, sampled in IDLE only
- core_id  in  ID_W  this core's index
- n_cores  in  ID_W  number of active cores
- imem_req  out  1  instruction fetch request
- imem_addr  out  PC_W  fetch address (= PC)
- imem_rdata  in  INSTR_W  instruction, valid when imem_ack=1
- imem_ack  in  1  fetch complete
- dmem_req  out  1  data access request
- dmem_we  out  1  1 = store, 0 = load
- dmem_addr  out  ADDR_W  data address
- dmem_wdata  out  DATA_W  store data
- dmem_rdata  in  DATA_W  load data, valid when dmem_ack=1
- dmem_ack  in  1  data access complete
- halted  out  1  core executed HALT
- pc_out  out  PC_W  current PC

## Operation
- States: IDLE, FETCH, EXEC, MEM, HALT.
- IDLE: if enable=1 go to FETCH, else stay.
- FETCH: imem_req=1, imem_addr=PC. On imem_ack, latch the instruction into IR and go to EXEC.
- EXEC: decode and execute. Register writeback happens at the end of EXEC, except for loads.
  - Non-memory ops: PC <= next, go to IDLE.
  - LOAD/LOADR/STORE/STORER: go to MEM.
  - HALT: go to HALT.
- MEM: dmem_req=1; dmem_addr, dmem_we and dmem_wdata held stable. On dmem_ack, a load writes ra <= dmem_rdata. Then PC <= PC+1, go to IDLE.
- HALT: halted=1, no requests. Only rst exits this state.
- Opcodes:
  - 0 NOP
  - 1 LDI: ra <= zext(imm)
  - 2 LOAD: ra <= M[imm]
  - 3 LOADR: ra <= M[rb[ADDR_W-1:0]]
  - 4 STORE: M[imm] <= ra
  - 5 STORER: M[rb[ADDR_W-1:0]] <= ra
  - 6 ADD: ra <= ra+rb
  - 7 SUB: ra <= ra-rb
  - 8 MUL: ra <= low DATA_W bits of ra*rb
  - 9 INC: ra <= ra+1
  - 10 JMP: PC <= imm[PC_W-1:0]
  - 11 JZ: jump if Z=1
  - 12 JNZ: jump if Z=0
  - 13 MOV: ra <= rb
  - 14 HALT
  - 15 reserved, executes as NOP
- Arithmetic is modulo 2^DATA_W; carry and overflow are discarded.
- Z flag: updated only by ADD/SUB/MUL/INC (Z = result==0); held otherwise. Reset value 0.
- PC: next = PC+1 modulo 2^PC_W, so 2^PC_W-1 wraps to 0. A taken jump overrides next.
- Register reset values:
  - R[NREG-1] = zext(core_id)
  - R[NREG-2] = zext(n_cores)
  - all others 0
  - core_id and n_cores are sampled on every rst cycle.
- A register write with ra=rb reads the old value for both operands (e.g. ADD R1,R1 doubles R1).

## Timing
- Reset, effective at the clock edge with rst=1:
  - state=IDLE, PC=0, IR=0, Z=0
  - imem_req=0, dmem_req=0, dmem_we=0, dmem_addr=0, dmem_wdata=0
  - halted=0, pc_out=0
- rst in any state, including mid-handshake, aborts the instruction. Requests drop the cycle after the reset edge, with no writeback. An ack arriving in the reset cycle is ignored.
- Fetch latency:
  - Ack in the same cycle as req gives a 1-cycle fetch.
  - Each cycle of ack=0 adds one cycle.
  - req stays high with a stable address until ack.
  - ack while req=0 is ignored.
- Instruction cost with zero wait states, IDLE included:
  - non-memory: 3 cycles (IDLE, FETCH, EXEC)
  - memory: 4 cycles (adds MEM)
- enable=0 stalls only at instruction boundaries. An in-flight instruction always completes.
- halted rises the cycle after HALT's EXEC and stays high.
- pc_out is the registered PC.

## Test plan
- Reset seeding: core_id=5, n_cores=4, rst 1 cycle, then LDI R0,7; HALT → R15=5, R14=4, R0=7; halted=1 on cycle 7 after rst release, with zero-wait acks.
- ALU/Z: LDI R1,3; LDI R2,3; SUB R1,R2; JZ 10 → PC=10 and Z=1. Then INC R1 → R1=1, Z=0. MUL of 0xFFFFFFFF by 2 → 0xFFFFFFFE.
- Wait states: imem_ack held low 3 cycles on every fetch, dmem_ack low 2 cycles → address/req stable throughout; STORE M[0x40]<=R0 writes exactly once; LOADR returns the stored value.
- PC wrap: NOPs filling all 64 locations → PC wraps 63→0; imem_addr sequence continuous.
- Reset mid-MEM: rst asserted while dmem_req=1 and a load is pending → target register unchanged, dmem_req=0 after the edge, PC=0.
- enable gating: enable dropped during FETCH → current instruction retires, core then stays in IDLE with no imem_req until enable=1.

Source files
------------

// File: rtl/proc_core_param.sv
// proc_core_param: parametrised multi-cycle core (IDLE/FETCH/EXEC/MEM/HALT).
// Each instruction fetches over a req/ack handshake and executes in one cycle.
// Loads and stores then spend at least one more cycle in a req/ack data
// access, so a shared arbiter can insert wait states on either port.
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   enable             start/continue permission, sampled in IDLE only
//   core_id, n_cores   seed values for R[NREG-1] / R[NREG-2] on reset
//   imem_*             instruction fetch handshake (addr = PC)
//   dmem_*             data load/store handshake
//   halted, pc_out     status: HALT executed, registered PC
module proc_core_param #(
  parameter  int DATA_W  = 32,
  parameter  int ADDR_W  = 12,
  parameter  int PC_W    = 6,
  parameter  int RIDX_W  = 4,
  parameter  int ID_W    = 3,
  localparam int INSTR_W = 4 + 2*RIDX_W + ADDR_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic [ID_W-1:0]    core_id,
  input  logic [ID_W-1:0]    n_cores,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               imem_ack,
  output logic               dmem_req,
  output logic               dmem_we,
  output logic [ADDR_W-1:0]  dmem_addr,
  output logic [DATA_W-1:0]  dmem_wdata,
  input  logic [DATA_W-1:0]  dmem_rdata,
  input  logic               dmem_ack,
  output logic               halted,
  output logic [PC_W-1:0]    pc_out
);
  localparam int NREG = 1 << RIDX_W;

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_EXEC, S_MEM, S_HALT} state_t;
  typedef enum logic [3:0] {
    OP_NOP, OP_LDI, OP_LOAD, OP_LOADR, OP_STORE, OP_STORER, OP_ADD, OP_SUB,
    OP_MUL, OP_INC, OP_JMP, OP_JZ, OP_JNZ, OP_MOV, OP_HALT, OP_RSVD
  } op_t;

  state_t            state;
  logic [PC_W-1:0]   pc;
  logic [INSTR_W-1:0] ir;
  logic              z_flag;
  logic [DATA_W-1:0] regs [NREG];

  // decode fields straight from IR
  op_t               op;
  logic [RIDX_W-1:0] ra, rb;
  logic [ADDR_W-1:0] imm;
  logic [DATA_W-1:0] va, vb;

  assign op  = op_t'(ir[INSTR_W-1 -: 4]);
  assign ra  = ir[INSTR_W-5 -: RIDX_W];
  assign rb  = ir[INSTR_W-5-RIDX_W -: RIDX_W];
  assign imm = ir[ADDR_W-1:0];
  // both operands read pre-write values, so ADD R1,R1 doubles R1
  assign va  = regs[ra];
  assign vb  = regs[rb];

  logic [DATA_W-1:0] res;
  logic              wr, zupd, jmp, mem, store;
  logic [ADDR_W-1:0] mem_addr;
  logic [PC_W-1:0]   pc_inc, pc_next;

  always_comb begin
    res   = '0;
    wr    = 1'b0;
    zupd  = 1'b0;
    jmp   = 1'b0;
    mem   = 1'b0;
    store = 1'b0;
    case (op)
      OP_LDI:    begin res = DATA_W'(imm);      wr = 1'b1; end
      OP_LOAD,
      OP_LOADR:  mem = 1'b1;
      OP_STORE,
      OP_STORER: begin mem = 1'b1; store = 1'b1; end
      OP_ADD:    begin res = va + vb;           wr = 1'b1; zupd = 1'b1; end
      OP_SUB:    begin res = va - vb;           wr = 1'b1; zupd = 1'b1; end
      OP_MUL:    begin res = va * vb;           wr = 1'b1; zupd = 1'b1; end
      OP_INC:    begin res = va + DATA_W'(1);   wr = 1'b1; zupd = 1'b1; end
      OP_JMP:    jmp = 1'b1;
      OP_JZ:     jmp = z_flag;
      OP_JNZ:    jmp = ~z_flag;
      OP_MOV:    begin res = vb;                wr = 1'b1; end
      default:   ;
    endcase
  end

  // immediate forms address by imm, register forms by the low bits of rb
  assign mem_addr = (op == OP_LOAD || op == OP_STORE) ? imm : vb[ADDR_W-1:0];
  assign pc_inc   = pc + PC_W'(1);
  assign pc_next  = jmp ? imm[PC_W-1:0] : pc_inc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      pc         <= '0;
      ir         <= '0;
      z_flag     <= 1'b0;
      imem_req   <= 1'b0;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
      halted     <= 1'b0;
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
      regs[NREG-1] <= DATA_W'(core_id);
      regs[NREG-2] <= DATA_W'(n_cores);
    end else begin
      case (state)
        S_IDLE: if (enable) begin
          imem_req <= 1'b1;
          state    <= S_FETCH;
        end
        S_FETCH: if (imem_ack) begin
          ir       <= imem_rdata;
          imem_req <= 1'b0;
          state    <= S_EXEC;
        end
        S_EXEC: begin
          if (wr)   regs[ra] <= res;
          if (zupd) z_flag   <= (res == '0);
          if (op == OP_HALT) begin
            halted <= 1'b1;
            state  <= S_HALT;
          end else if (mem) begin
            dmem_req   <= 1'b1;
            dmem_we    <= store;
            dmem_addr  <= mem_addr;
            dmem_wdata <= va;
            state      <= S_MEM;
          end else begin
            pc    <= pc_next;
            state <= S_IDLE;
          end
        end
        S_MEM: if (dmem_ack) begin
          if (!dmem_we) regs[ra] <= dmem_rdata;
          dmem_req <= 1'b0;
          dmem_we  <= 1'b0;
          pc       <= pc_inc;
          state    <= S_IDLE;
        end
        S_HALT:  halted <= 1'b1;
        default: state  <= S_IDLE;
      endcase
    end
  end

  assign imem_addr = pc;
  assign pc_out    = pc;

endmodule
